// File: rtl/onchip_ram_avalon.sv
// onchip_ram_avalon: dual-port Avalon-MM on-chip RAM with byte enables, reset-time zero fill and s1-priority write arbitration
module onchip_ram_avalon #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 17,
  parameter int DEPTH          = 98304,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  typedef enum logic {INIT, READY} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic [NB-1:0] be [2];
  logic [DATA_WIDTH-1:0] d1_q [2];
  logic [DATA_WIDTH-1:0] d2_q [2];
  logic [1:0] cs, rd, wr, wait_r, in_rng, wr_acc, rd_acc, v1_q, v2_q;
  logic clash, init_done;
  assign addr[0]  = s1_address;
  assign addr[1]  = s2_address;
  assign wdata[0] = s1_writedata;
  assign wdata[1] = s2_writedata;
  assign be[0]    = s1_byteenable;
  assign be[1]    = s2_byteenable;
  assign cs       = {s2_chipselect, s1_chipselect};
  assign rd       = {s2_read, s1_read};
  assign wr       = {s2_write, s1_write};
  for (genvar i = 0; i < 2; i++) begin : g_port
    assign in_rng[i] = {1'b0, addr[i]} < LIMIT;
    assign wr_acc[i] = cs[i] & wr[i] & ~wait_r[i];
    assign rd_acc[i] = cs[i] & rd[i] & ~wr[i] & ~wait_r[i];
  end
  // s2 yields only on a true same-word write collision; s1 wins, s2 retries next cycle
  assign clash     = cs[0] & wr[0] & cs[1] & wr[1] & in_rng[0] & (addr[0] == addr[1]);
  assign wait_r[0] = ~(state_q == READY && clken);
  assign wait_r[1] = wait_r[0] | clash;
  assign init_done = CLEAR_ON_RESET == 0 || ptr_q == LAST;
  always_comb begin
    state_d = (state_q == INIT && clken && init_done) ? READY : state_q;
    ptr_d   = (state_q == INIT && clken && !init_done) ? ptr_q + 1'b1 : ptr_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (clken) begin
      if (state_q == INIT && CLEAR_ON_RESET != 0) mem[ptr_q] <= '0;
      for (int p = 0; p < 2; p++)
        if (wr_acc[p] && in_rng[p])
          for (int b = 0; b < NB; b++)
            if (be[p][b]) mem[addr[p][IW-1:0]][b*8 +: 8] <= wdata[p][b*8 +: 8];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q <= '0;
      v2_q <= '0;
      for (int p = 0; p < 2; p++) begin
        d1_q[p] <= '0;
        d2_q[p] <= '0;
      end
    end else if (clken) begin
      v1_q <= rd_acc;
      v2_q <= v1_q;
      for (int p = 0; p < 2; p++) begin
        d1_q[p] <= in_rng[p] ? mem[addr[p][IW-1:0]] : '0;
        d2_q[p] <= d1_q[p];
      end
    end
  end
  assign s1_readdata      = READ_LATENCY == 2 ? d2_q[0] : d1_q[0];
  assign s2_readdata      = READ_LATENCY == 2 ? d2_q[1] : d1_q[1];
  assign s1_readdatavalid = READ_LATENCY == 2 ? v2_q[0] : v1_q[0];
  assign s2_readdatavalid = READ_LATENCY == 2 ? v2_q[1] : v1_q[1];
  assign s1_waitrequest   = wait_r[0];
  assign s2_waitrequest   = wait_r[1];
endmodule
